tm1638_frame_sched: RTL and testbench

// - Shares the single TM1638 LED-frame path between up to NSRC LED-pattern generators.
// - Picks one source with a debounced button; the optional auto mode also rotates on a dwell timer.
// - Latches the chosen 8-bit pattern and hands it to the TM1638 driver with a req/ack handshake.
// - Sits between the pattern generators and the TM1638 driver in the top level.

---
 rtl/tm1638_frame_sched_if.sv | 23 ++
 rtl/tm1638_frame_sched.sv | 143 ++++++++++++++
 tb/tb_tm1638_frame_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_frame_sched_if.sv
// Bundles the pattern-source, button and TM1638 driver handshake signals of the frame scheduler.
interface tm1638_frame_sched_if #(
   parameter int NSRC = 4
);
   logic                btn;
   logic [8*NSRC-1:0]   src_led;
   logic [NSRC-1:0]     src_valid;
   logic                frame_ack;
   logic [7:0]          led_out;
   logic [1:0]          sel;
   logic                frame_req;
   logic                busy;

   modport master (
      input  btn, src_led, src_valid, frame_ack,
      output led_out, sel, frame_req, busy
   );

   modport slave (
      output btn, src_led, src_valid, frame_ack,
      input  led_out, sel, frame_req, busy
   );
endinterface

// File: rtl/tm1638_frame_sched.sv
// Selects one of NSRC LED patterns by debounced button and hands it to the TM1638 driver via req/ack.
// Define TM1638_FRAME_SCHED_AUTO_ROTATE_EN for long-press auto-rotation on a dwell timer.
module tm1638_frame_sched #(
   parameter int NSRC         = 4,
   parameter int DEB_CYCLES   = 1_000_000,
   parameter int DWELL_CYCLES = 100_000_000
) (
   input  logic                    clk_50M,
   input  logic                    rs,
   tm1638_frame_sched_if.master    bus
);
   localparam int DW = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT_ACK} state_t;

   logic          btn_s1, btn_s2, deb_lvl, acc;
   logic [DW-1:0] deb_cnt;
   logic          step;
   state_t        state;
   logic          sel_pend;
   logic [3:0]    vld4;
   logic [31:0]   led4;
   logic [1:0]    nxt, cand;
   logic          found;
   logic [7:0]    target;

   // acc pulses for one cycle after deb_lvl takes a new value
   always_ff @(posedge clk_50M or posedge rs) begin
      if (rs) begin
         btn_s1  <= 1'b0;
         btn_s2  <= 1'b0;
         deb_lvl <= 1'b0;
         deb_cnt <= '0;
         acc     <= 1'b0;
      end else begin
         btn_s1 <= bus.btn;
         btn_s2 <= btn_s1;
         acc    <= 1'b0;
         if (btn_s2 == deb_lvl) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            deb_lvl <= btn_s2;
            deb_cnt <= '0;
            acc     <= 1'b1;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

`ifdef TM1638_FRAME_SCHED_AUTO_ROTATE_EN
   localparam int LONG = 8 * DEB_CYCLES;
   localparam int HW   = $clog2(LONG + 1);
   localparam int WW   = $clog2(DWELL_CYCLES + 1);

   logic [HW-1:0] hold_cnt;
   logic [WW-1:0] dwell_cnt;
   logic          auto_on, fall, short_press, tick;

   // Short presses act on release so a long hold never steps the selection.
   assign fall        = acc && !deb_lvl;
   assign short_press = fall && (hold_cnt != HW'(LONG));
   assign tick        = auto_on && (dwell_cnt == WW'(DWELL_CYCLES - 1));
   assign step        = short_press || tick;

   always_ff @(posedge clk_50M or posedge rs) begin
      if (rs) begin
         hold_cnt  <= '0;
         dwell_cnt <= '0;
         auto_on   <= 1'b0;
      end else begin
         if (!deb_lvl)
            hold_cnt <= '0;
         else if (hold_cnt != HW'(LONG))
            hold_cnt <= hold_cnt + 1'b1;
         if (deb_lvl && hold_cnt == HW'(LONG - 1))
            auto_on <= !auto_on;
         if (!auto_on || short_press || tick)
            dwell_cnt <= '0;
         else
            dwell_cnt <= dwell_cnt + 1'b1;
      end
   end
`else
   assign step = acc && deb_lvl;
`endif

   assign vld4 = 4'(bus.src_valid);
   assign led4 = 32'(bus.src_led);

   // Nearest valid source after sel, wrapping modulo NSRC.
   always_comb begin
      nxt   = bus.sel;
      cand  = '0;
      found = 1'b0;
      for (int i = NSRC - 1; i >= 1; i--) begin
         cand = 2'((int'(bus.sel) + i) % NSRC);
         if (vld4[cand]) begin
            nxt   = cand;
            found = 1'b1;
         end
      end
      target = vld4[bus.sel] ? led4[{bus.sel, 3'b000} +: 8] : 8'h00;
   end

   // sel_pend remembers a selection change made while a frame was in flight.
   always_ff @(posedge clk_50M or posedge rs) begin
      if (rs) begin
         state         <= IDLE;
         bus.led_out   <= 8'h00;
         bus.sel       <= 2'd0;
         bus.frame_req <= 1'b0;
         bus.busy      <= 1'b0;
         sel_pend      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (target != bus.led_out || sel_pend) begin
               state    <= LOAD;
               bus.busy <= 1'b1;
               sel_pend <= 1'b0;
            end
            LOAD: begin
               bus.led_out <= target;
               state       <= REQ;
            end
            REQ: begin
               bus.frame_req <= 1'b1;
               state         <= WAIT_ACK;
            end
            WAIT_ACK: if (bus.frame_ack) begin
               bus.frame_req <= 1'b0;
               bus.busy      <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if ((step || !vld4[bus.sel]) && found) begin
            bus.sel  <= nxt;
            sel_pend <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_tm1638_frame_sched.sv
// Self-checking bench for tm1638_frame_sched: vector table for button selection, scoreboard for frames.
module tb_tm1638_frame_sched;
   logic clk = 1'b0;
   logic rs;
   always #5 clk = ~clk;

   tm1638_frame_sched_if #(.NSRC(4)) bus();

   tm1638_frame_sched #(.NSRC(4), .DEB_CYCLES(4), .DWELL_CYCLES(32)) dut (
      .clk_50M (clk),
      .rs      (rs),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   typedef struct {
      logic [3:0] valid;
      logic       has_frame;
      logic [1:0] exp_sel;
      logic [7:0] exp_led;
   } vec_t;
   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input int max, output int n);
      n = 0;
      while (bus.frame_req !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic take_frame(input string nm, output logic [7:0] e);
      e = 8'h00;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: unexpected frame %0h, scoreboard empty", nm, bus.led_out);
      end else begin
         e = sb.pop_front();
         chk(nm, bus.led_out, e);
      end
   endtask

   task automatic ack_frame(input string nm);
      bus.frame_ack = 1'b1;
      cyc(1);
      bus.frame_ack = 1'b0;
      chk({nm, "_req_drop"}, bus.frame_req, 0);
   endtask

   task automatic serve(input string nm, input int dly);
      int n;
      logic [7:0] e;
      wait_req(40, n);
      chk({nm, "_req_seen"}, bus.frame_req, 1);
      if (bus.frame_req === 1'b1) begin
         take_frame(nm, e);
         cyc(dly);
         chk({nm, "_frozen"}, bus.led_out, e);
         ack_frame(nm);
      end
   endtask

   task automatic press(input int hold);
      bus.btn = 1'b1;
      cyc(hold);
      bus.btn = 1'b0;
      cyc(8);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, bad;
      logic [7:0] e;
      logic [1:0] s;

      vt[0] = '{4'b1011, 1'b1, 2'd1, 8'hA2};
      vt[1] = '{4'b1011, 1'b1, 2'd3, 8'hA4};
      vt[2] = '{4'b1011, 1'b1, 2'd0, 8'h03};
      vt[3] = '{4'b0001, 1'b0, 2'd0, 8'h03};
      vt[4] = '{4'b0101, 1'b1, 2'd2, 8'hA3};
      vt[5] = '{4'b0101, 1'b1, 2'd0, 8'h03};
      vt[6] = '{4'b1111, 1'b1, 2'd1, 8'hA2};
      vt[7] = '{4'b1111, 1'b1, 2'd2, 8'hA3};
      vt[8] = '{4'b1111, 1'b1, 2'd3, 8'hA4};
      vt[9] = '{4'b1001, 1'b1, 2'd0, 8'h03};

      rs            = 1'b1;
      bus.btn       = 1'b0;
      bus.frame_ack = 1'b0;
      bus.src_valid = 4'hF;
      bus.src_led   = {8'hA4, 8'hA3, 8'hA2, 8'h01};
      cyc(3);
      chk("rst_sel", bus.sel, 0);
      chk("rst_led", bus.led_out, 8'h00);
      chk("rst_req", bus.frame_req, 0);
      chk("rst_busy", bus.busy, 0);

      sb.push_back(8'h01);
      rs = 1'b0;
      wait_req(10, n);
      chk("rst_latency", n, 3);
      take_frame("rst_frame", e);
      chk("busy_in_wait", bus.busy, 1);

      // Pattern change while waiting for ack must not disturb the frozen frame.
      bus.src_led[7:0] = 8'h03;
      sb.push_back(8'h03);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (bus.led_out !== 8'h01 || bus.frame_req !== 1'b1) bad++;
      end
      chk("hold_until_ack", bad, 0);
      ack_frame("hs1");
      serve("hs2", 2);

      bus.btn = 1'b1;
      cyc(2);
      bus.btn = 1'b0;
      cyc(12);
      chk("glitch_sel", bus.sel, 0);
      chk("glitch_req", bus.frame_req, 0);

      for (int i = 0; i < 10; i++) begin
         bus.src_valid = vt[i].valid;
         cyc(2);
         if (vt[i].has_frame) sb.push_back(vt[i].exp_led);
         press(8);
         if (vt[i].has_frame) begin
            serve($sformatf("row%0d_frame", i), 2);
         end else begin
            cyc(10);
            chk($sformatf("row%0d_noframe", i), bus.frame_req, 0);
         end
         chk($sformatf("row%0d_sel", i), bus.sel, vt[i].exp_sel);
         chk($sformatf("row%0d_led", i), bus.led_out, vt[i].exp_led);
      end

      bus.src_valid = 4'b0001;
      cyc(4);
      chk("inval_pre_req", bus.frame_req, 0);
      bus.src_valid = 4'b0000;
      sb.push_back(8'h00);
      serve("inval_frame", 2);
      cyc(10);
      chk("inval_sel", bus.sel, 0);
      chk("inval_led", bus.led_out, 8'h00);
      chk("inval_no_more", bus.frame_req, 0);

      bus.src_valid = 4'hF;
      sb.push_back(8'h03);
      wait_req(20, n);
      chk("mid_req_seen", bus.frame_req, 1);
      take_frame("mid_frame", e);
      cyc(2);
      #2 rs = 1'b1;
      #1;
      chk("mid_rst_req", bus.frame_req, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_led", bus.led_out, 8'h00);
      cyc(1);
      rs = 1'b0;
      bus.frame_ack = 1'b1;
      sb.push_back(8'h03);
      cyc(1);
      bus.frame_ack = 1'b0;
      chk("late_ack_req", bus.frame_req, 0);
      wait_req(10, n);
      chk("rst2_latency", n + 1, 3);
      take_frame("rst2_frame", e);
      cyc(3);
      chk("late_ack_ignored", bus.frame_req, 1);
      ack_frame("rst2");

`ifdef TM1638_FRAME_SCHED_AUTO_ROTATE_EN
      bus.src_valid = 4'b1011;
      cyc(2);
      press(40);
      chk("long_no_step", bus.sel, 0);
      chk("long_no_frame", bus.frame_req, 0);
      sb.push_back(8'hA2);
      serve("auto0", 2);
      chk("auto0_sel", bus.sel, 1);
      sb.push_back(8'hA4);
      serve("auto1", 2);
      chk("auto1_sel", bus.sel, 3);
      sb.push_back(8'h03);
      serve("auto2", 2);
      chk("auto2_sel", bus.sel, 0);
      press(40);
      for (int i = 0; i < 60; i++) begin
         if (bus.frame_req === 1'b1) begin
            bus.frame_ack = 1'b1;
            cyc(1);
            bus.frame_ack = 1'b0;
         end else begin
            cyc(1);
         end
      end
      s = bus.sel;
      cyc(80);
      chk("auto_stopped_sel", bus.sel, s);
      chk("auto_stopped_req", bus.frame_req, 0);
`endif

      cyc(10);
      chk("sb_empty", sb.size(), 0);
      chk("final_req", bus.frame_req, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
